// File: rtl/led_pkg.sv
// Shared encodings for the LED scanner: run modes, scan direction and the
// channel-index width helper.
package led_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_ALL    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_scan_pwm_if.sv
// Pin-level bundle of the LED scanner: run controls in, LED drive and status out.
interface led_scan_pwm_if
  import led_pkg::*;
#(
  parameter int NOUT  = 56,
  parameter int PWM_W = 4
);
  localparam int CW = idx_width(NOUT);

  logic             enable;
  logic [1:0]       mode;
  logic [NOUT-1:0]  out;
  logic [CW-1:0]    chan_idx;
  logic [PWM_W-1:0] level;
  logic             cycle_done;

  modport master (output enable, mode, input out, chan_idx, level, cycle_done);
  modport slave  (input enable, mode, output out, chan_idx, level, cycle_done);

endinterface

// File: rtl/led_sd_pwm.sv
// First-order sigma-delta modulator: the carry out of a W-bit accumulator
// gives a pulse density of level / 2^W.
module led_sd_pwm #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic         pwm
);

  logic [W:0] acc_q, acc_d;

  assign acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, level};
  assign pwm   = acc_q[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/led_scan_pwm.sv
// LED chaser/breather: prescaled triangle ramp, sigma-delta dimming and a
// channel scanner. Define LED_SCAN_TRAIL_EN for a half-brightness trailing LED.
//
// dir_q    | meaning
// DIR_UP   | scan index moves towards NOUT-1
// DIR_DOWN | scan index moves towards 0 (BOUNCE only)
module led_scan_pwm
  import led_pkg::*;
#(
  parameter int NOUT    = 56,
  parameter int PWM_W   = 4,
  parameter int PRESC_W = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  led_scan_pwm_if.slave led
);

  localparam int CW = idx_width(NOUT);
  localparam logic [CW-1:0] IDX_LAST = CW'(NOUT - 1);
  localparam logic [CW-1:0] IDX_PREV = CW'((NOUT > 1) ? NOUT - 2 : 0);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W:0]     phase_q, phase_d;
  logic [CW-1:0]      idx_q, idx_d;
  dir_e               dir_q, dir_d;
  logic [NOUT-1:0]    out_q, out_d;
  logic               cdone_q, cdone_d;

  logic               tick, hold_mode, advance, pwm_main;
  logic [PWM_W-1:0]   level_w;

  assign tick      = led.enable && (presc_q == '1);
  assign hold_mode = (led.mode == MODE_HOLD);
  assign advance   = tick && !hold_mode && (phase_q == '1);
  assign level_w   = phase_q[PWM_W] ? ~phase_q[PWM_W-1:0] : phase_q[PWM_W-1:0];

  led_sd_pwm #(.W(PWM_W)) u_main (.clk(clk), .rst_n(rst_n), .level(level_w), .pwm(pwm_main));

  always_comb begin : ramp_next
    presc_d = presc_q;
    phase_d = phase_q;
    if (led.enable) presc_d = presc_q + PRESC_W'(1);
    if (tick && !hold_mode) phase_d = phase_q + (PWM_W+1)'(1);
  end

  always_comb begin : scan_next
    idx_d   = idx_q;
    dir_d   = dir_q;
    cdone_d = 1'b0;
    if (advance) begin
      case (led.mode)
        MODE_WRAP: begin
          dir_d = DIR_UP;
          if (idx_q >= IDX_LAST) begin
            idx_d   = '0;
            cdone_d = 1'b1;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
        MODE_BOUNCE: begin
          if (NOUT == 1) begin
            idx_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (idx_q >= IDX_LAST) begin
              dir_d = DIR_DOWN;
              idx_d = IDX_PREV;
            end else begin
              idx_d = idx_q + CW'(1);
            end
          end else begin
            if (idx_q == '0) begin
              dir_d = DIR_UP;
              idx_d = CW'(1);
            end else begin
              idx_d = idx_q - CW'(1);
            end
          end
          cdone_d = (idx_d == '0);
        end
        MODE_ALL: cdone_d = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LED_SCAN_TRAIL_EN
  logic          pwm_trail, trail_on;
  logic [CW-1:0] trail_idx;

  led_sd_pwm #(.W(PWM_W)) u_trail (.clk(clk), .rst_n(rst_n), .level(level_w >> 1), .pwm(pwm_trail));

  // Trail sits on the channel the scan just left; at the bounce ends it clamps.
  always_comb begin : trail_pick
    trail_idx = idx_q;
    if (led.mode == MODE_WRAP)   trail_idx = (idx_q == '0) ? IDX_LAST : idx_q - CW'(1);
    else if (dir_q == DIR_UP)    trail_idx = (idx_q == '0) ? idx_q : idx_q - CW'(1);
    else                         trail_idx = (idx_q >= IDX_LAST) ? idx_q : idx_q + CW'(1);
  end

  assign trail_on = (NOUT > 1) && ((led.mode == MODE_WRAP) || (led.mode == MODE_BOUNCE));
`endif

  always_comb begin : pin_next
    out_d = '0;
    for (int i = 0; i < NOUT; i++) begin
      if ((led.mode == MODE_ALL) || (idx_q == CW'(i))) out_d[i] = pwm_main;
`ifdef LED_SCAN_TRAIL_EN
      if (trail_on && (trail_idx == CW'(i))) out_d[i] = out_d[i] | pwm_trail;
`endif
    end
    if (!led.enable) out_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      dir_q   <= DIR_UP;
      out_q   <= '0;
      cdone_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      cdone_q <= cdone_d;
    end
  end

  assign led.out        = out_q;
  assign led.chan_idx   = idx_q;
  assign led.level      = level_w;
  assign led.cycle_done = cdone_q;

endmodule

// File: tb/tb_led_scan_pwm.sv
// Directed bench for led_scan_pwm with NOUT=4, PWM_W=2, PRESC_W=2
// (tick every 4 clocks, scan advance every 32 clocks).
module tb_led_scan_pwm;
  import led_pkg::*;

  localparam int NOUT    = 4;
  localparam int PWM_W   = 2;
  localparam int PRESC_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  led_scan_pwm_if #(.NOUT(NOUT), .PWM_W(PWM_W)) bus ();

  led_scan_pwm #(.NOUT(NOUT), .PWM_W(PWM_W), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .led  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          n_clk;
    int          exp_cd;
    int          exp_idx;
    int          exp_level;
    int          seq_len;
    logic [15:0] exp_seq;     // 2-bit index entries, entry k at bits [2k+1:2k]
    bit          exp_active;
    string       name;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cd_cnt, viol, hi, seq_len, prev_idx, err, cnt, found;
    logic [15:0] seq;
    logic [NOUT-1:0] allow;

    vecs[0] = '{MODE_WRAP,   124, 1, 0, 0, 5, 16'h00E4, 1'b1, "wrap"};
    vecs[1] = '{MODE_BOUNCE, 224, 1, 1, 0, 8, 16'h46E4, 1'b1, "bounce"};
    vecs[2] = '{MODE_ALL,     64, 2, 1, 0, 1, 16'h0001, 1'b1, "all"};
    vecs[3] = '{MODE_WRAP,     9, 0, 1, 2, 1, 16'h0001, 1'b0, "wrap_short"};

    bus.enable = 1'b1;
    bus.mode   = MODE_WRAP;
    #2 rst_n = 1'b0;
    step(2);
    check("reset out", int'(bus.out), 0);
    check("reset idx", int'(bus.chan_idx), 0);
    check("reset level", int'(bus.level), 0);
    check("reset cycle_done", int'(bus.cycle_done), 0);
    rst_n = 1'b1;
    step(3);
    check("pre-tick level", int'(bus.level), 0);
    step(1);
    check("first tick level", int'(bus.level), 1);

    for (int v = 0; v < 4; v++) begin
      bus.mode = vecs[v].mode;
      cd_cnt   = 0;
      viol     = 0;
      hi       = 0;
      seq_len  = 1;
      seq      = '0;
      seq[1:0] = bus.chan_idx;
      prev_idx = int'(bus.chan_idx);
      for (int c = 0; c < vecs[v].n_clk; c++) begin
        step(1);
        if (bus.cycle_done) begin
          cd_cnt++;
          if (vecs[v].mode != MODE_ALL && bus.chan_idx != '0) viol++;
        end
        if (int'(bus.chan_idx) != prev_idx) begin
          if (seq_len < 8) seq[2*seq_len +: 2] = bus.chan_idx;
          seq_len++;
        end
        // out is registered, so right after an advance it may still show the previous channel
        allow = (NOUT'(1) << bus.chan_idx) | (NOUT'(1) << prev_idx);
        if (c > 0) begin
          if (vecs[v].mode == MODE_ALL) begin
            if (bus.out != '0 && bus.out != '1) viol++;
          end else if ((bus.out & ~allow) != '0) begin
            viol++;
          end
        end
        if (bus.out != '0) hi++;
        prev_idx = int'(bus.chan_idx);
      end
      check($sformatf("%s cycle_done count", vecs[v].name), cd_cnt, vecs[v].exp_cd);
      check($sformatf("%s end idx", vecs[v].name), int'(bus.chan_idx), vecs[v].exp_idx);
      check($sformatf("%s end level", vecs[v].name), int'(bus.level), vecs[v].exp_level);
      check($sformatf("%s idx seq length", vecs[v].name), seq_len, vecs[v].seq_len);
      check($sformatf("%s idx seq", vecs[v].name), int'(seq), int'(vecs[v].exp_seq));
      check($sformatf("%s pin violations", vecs[v].name), viol, 0);
      if (vecs[v].exp_active) check($sformatf("%s out activity", vecs[v].name), int'(hi > 0), 1);
    end

    bus.enable = 1'b0;
    step(1);
    check("disable out next clk", int'(bus.out), 0);
    err = 0;
    for (int c = 0; c < 49; c++) begin
      step(1);
      if (bus.out != '0 || bus.level != 2'd2 || bus.chan_idx != 2'd1 || bus.cycle_done) err++;
    end
    check("disabled frozen state errors", err, 0);
    check("disabled level", int'(bus.level), 2);
    check("disabled idx", int'(bus.chan_idx), 1);
    bus.enable = 1'b1;
    step(2);
    check("resume level before tick", int'(bus.level), 2);
    step(1);
    check("resume level after tick", int'(bus.level), 3);

    bus.mode = MODE_HOLD;
    step(4);
    err = 0;
    for (int w = 0; w < 4; w++) begin
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
        step(1);
        cnt += int'(bus.out[1]);
        if ((bus.out & 4'b1101) != '0) err++;
      end
      check($sformatf("hold level3 density window %0d", w), cnt, 3);
    end
    check("hold other pins", err, 0);
    step(44);
    check("hold level frozen", int'(bus.level), 3);
    check("hold idx frozen", int'(bus.chan_idx), 1);

    bus.mode = MODE_WRAP;
    step(16);
    check("ramp down to level 0", int'(bus.level), 0);
    check("idx before wrap", int'(bus.chan_idx), 1);
    bus.mode = MODE_HOLD;
    step(2);
    cnt = 0;
    for (int c = 0; c < 64; c++) begin
      step(1);
      if (bus.out != '0) cnt++;
    end
    check("hold level0 out high clocks", cnt, 0);
    check("hold level0 level", int'(bus.level), 0);

    bus.mode = MODE_ALL;
    found = 0;
    for (int c = 0; c < 64 && found == 0; c++) begin
      step(1);
      if (bus.out != '0) found = 1;
    end
    check("out active before reset", found, 1);
    check("idx before reset", int'(bus.chan_idx), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out", int'(bus.out), 0);
    check("async reset idx", int'(bus.chan_idx), 0);
    check("async reset level", int'(bus.level), 0);
    repeat (3) @(posedge clk);
    #1;
    check("held reset out", int'(bus.out), 0);
    check("held reset cycle_done", int'(bus.cycle_done), 0);
    check("held reset level", int'(bus.level), 0);
    rst_n = 1'b1;
    step(3);
    check("post-reset pre-tick level", int'(bus.level), 0);
    step(1);
    check("post-reset first tick level", int'(bus.level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
